// File: rtl/eth_apb_mem_responder.sv
// APB completer backing the Ethernet MAC's DMA master port with a word memory.
// Programmable wait states, out-of-range/misaligned handling, and a sticky
// protocol-violation flag.
module eth_apb_mem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] OOR_DATA  = 32'hDEAD_BEEF
) (
    input  logic        pclk_i,
    input  logic        prst_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [31:0] paddr_i,
    input  logic [31:0] pwdata_i,
    input  logic [3:0]  wait_cfg_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        perr_o,
    output logic        oor_o,
    output logic [15:0] acc_cnt_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] lat_addr, lat_addr_n;
    logic [31:0] lat_wdata, lat_wdata_n;
    logic        lat_write, lat_write_n;
    logic [31:0] prdata_n;
    logic        pready_n, perr_n, oor_n;
    logic [15:0] acc_n;
    logic        mem_we;

    logic [31:0] mem [0:DEPTH-1];

    // Decode both the live bus address (setup phase) and the latched one
    // (everything after setup uses the latched copy).
    logic [31:0] idx_in, idx_lat, rd_in, rd_lat;
    logic        hit_in, hit_lat, bus_changed;

    assign idx_in  = (paddr_i - BASE_ADDR) >> 2;
    assign idx_lat = (lat_addr - BASE_ADDR) >> 2;
    assign hit_in  = (paddr_i >= BASE_ADDR) && (idx_in < 32'(DEPTH)) && (paddr_i[1:0] == 2'b00);
    assign hit_lat = (lat_addr >= BASE_ADDR) && (idx_lat < 32'(DEPTH)) && (lat_addr[1:0] == 2'b00);
    assign rd_in   = hit_in  ? mem[idx_in[AW-1:0]]  : OOR_DATA;
    assign rd_lat  = hit_lat ? mem[idx_lat[AW-1:0]] : OOR_DATA;

    assign bus_changed = (paddr_i != lat_addr) || (pwrite_i != lat_write) || (pwdata_i != lat_wdata);

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        lat_addr_n  = lat_addr;
        lat_wdata_n = lat_wdata;
        lat_write_n = lat_write;
        prdata_n    = prdata_o;
        pready_n    = pready_o;
        perr_n      = perr_o;
        oor_n       = 1'b0;
        acc_n       = acc_cnt_o;
        mem_we      = 1'b0;
        case (state)
            IDLE: begin
                if (psel_i && !penable_i) begin
                    lat_addr_n  = paddr_i;
                    lat_wdata_n = pwdata_i;
                    lat_write_n = pwrite_i;
                    if (wait_cfg_i == 4'd0) begin
                        pready_n = 1'b1;
                        prdata_n = pwrite_i ? 32'd0 : rd_in;
                        state_n  = ACCESS;
                    end else begin
                        cnt_n   = wait_cfg_i;
                        state_n = WAIT;
                    end
                end else if (psel_i && penable_i) begin
                    // Access phase with no setup: flag it, never respond.
                    perr_n = 1'b1;
                end
            end
            WAIT: begin
                if (!psel_i) begin
                    perr_n   = 1'b1;
                    pready_n = 1'b0;
                    prdata_n = 32'd0;
                    state_n  = IDLE;
                end else begin
                    if (!penable_i || bus_changed) perr_n = 1'b1;
                    if (penable_i) begin
                        cnt_n = cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            pready_n = 1'b1;
                            prdata_n = lat_write ? 32'd0 : rd_lat;
                            state_n  = ACCESS;
                        end
                    end
                end
            end
            ACCESS: begin
                if (!psel_i) begin
                    perr_n   = 1'b1;
                    pready_n = 1'b0;
                    prdata_n = 32'd0;
                    state_n  = IDLE;
                end else begin
                    if (!penable_i || bus_changed) perr_n = 1'b1;
                    if (penable_i && pready_o) begin
                        mem_we   = lat_write && hit_lat;
                        acc_n    = acc_cnt_o + 16'd1;
                        oor_n    = !hit_lat;
                        pready_n = 1'b0;
                        prdata_n = 32'd0;
                        state_n  = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; synchronous reset wins over any transfer.
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_write <= 1'b0;
            prdata_o  <= 32'd0;
            pready_o  <= 1'b0;
            perr_o    <= 1'b0;
            oor_o     <= 1'b0;
            acc_cnt_o <= 16'd0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            lat_addr  <= lat_addr_n;
            lat_wdata <= lat_wdata_n;
            lat_write <= lat_write_n;
            prdata_o  <= prdata_n;
            pready_o  <= pready_n;
            perr_o    <= perr_n;
            oor_o     <= oor_n;
            acc_cnt_o <= acc_n;
        end
    end

    // Memory write at completion only; contents survive reset.
    always_ff @(posedge pclk_i) begin
        if (!prst_i && mem_we) mem[idx_lat[AW-1:0]] <= lat_wdata;
    end
endmodule

// File: tb/tb_eth_apb_mem_responder.sv
// Self-checking bench: directed scenarios plus randomized transfers against a
// word-array reference model of the memory and completion counter.
module tb_eth_apb_mem_responder;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          DEP  = 1024;
    localparam logic [31:0] OOR  = 32'hDEAD_BEEF;

    logic        clk, rst, psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  wait_cfg;
    logic        pready, perr, oor;
    logic [15:0] acc;

    int errors = 0;
    int checks = 0;

    // reference model
    logic [31:0]  mm [DEP];
    int unsigned  wq[$];
    logic [15:0]  exp_acc;

    eth_apb_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEP), .OOR_DATA(OOR)) dut (
        .pclk_i(clk), .prst_i(rst), .psel_i(psel), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .wait_cfg_i(wait_cfg),
        .prdata_o(prdata), .pready_o(pready), .perr_o(perr), .oor_o(oor), .acc_cnt_o(acc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit m_hit(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) / 4) < DEP) && (a % 4 == 0);
    endfunction

    function automatic int unsigned m_idx(input logic [31:0] a);
        return (a - BASE) / 4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full APB transfer; starts and ends 1 time unit after a rising edge.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] ws, output logic [31:0] rd, output int lows,
                        output logic oor_s, output logic rdy_after, output logic tmo);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; wait_cfg = ws;
        tick();
        penable = 1'b1;
        lows = 0;
        tmo = 1'b0;
        while (pready !== 1'b1 && lows < 40) begin
            lows++;
            tick();
        end
        if (pready !== 1'b1) tmo = 1'b1;
        rd = prdata;
        tick();
        oor_s = oor;
        rdy_after = pready;
        psel = 1'b0; penable = 1'b0;
        exp_acc = exp_acc + 16'd1;
        if (w && m_hit(a)) begin
            mm[m_idx(a)] = d;
            wq.push_back(m_idx(a));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; psel = 1'b0; penable = 1'b0;
        tick();
        rst = 1'b0;
        exp_acc = 16'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'd0; pwdata = 32'd0; wait_cfg = 4'd0;
        tick(); tick();
        checks++;
        if ({prdata, pready, perr, oor, acc} !== 51'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h/%b/%b/%b/%h want all zero", prdata, pready, perr, oor, acc);
        end
        rst = 1'b0;
        exp_acc = 16'd0;
    endtask

    task automatic test_basic();
        logic [31:0] rd; int lows; logic o, ra, tmo;
        xfer(1'b1, 32'h10, 32'hA5A5_0001, 4'd0, rd, lows, o, ra, tmo);
        checks++;
        if (tmo || lows != 0) begin errors++; $display("FAIL basic_wr_lows got=%0d want=0", lows); end
        xfer(1'b0, 32'h10, 32'h0, 4'd0, rd, lows, o, ra, tmo);
        checks++;
        if (tmo || lows != 0) begin errors++; $display("FAIL basic_rd_lows got=%0d want=0", lows); end
        checks++;
        if (rd !== 32'hA5A5_0001) begin errors++; $display("FAIL basic_rd_data got=%h want=a5a50001", rd); end
        checks++;
        if (acc !== 16'd2 || perr !== 1'b0) begin
            errors++; $display("FAIL basic_acc_perr got=%0d/%b want=2/0", acc, perr);
        end
    endtask

    task automatic test_wait();
        logic [31:0] rd; int lows; logic o, ra, tmo;
        xfer(1'b0, 32'h10, 32'h0, 4'd3, rd, lows, o, ra, tmo);
        checks++;
        if (tmo || lows != 3) begin errors++; $display("FAIL wait_lows got=%0d want=3", lows); end
        checks++;
        if (rd !== 32'hA5A5_0001 || ra !== 1'b0) begin
            errors++; $display("FAIL wait_data got=%h rdy_after=%b want=a5a50001/0", rd, ra);
        end
    endtask

    task automatic test_oor();
        logic [31:0] rd; int lows; logic o, ra, tmo;
        xfer(1'b1, 32'h0, 32'h1234_5678, 4'd0, rd, lows, o, ra, tmo);
        xfer(1'b0, 32'h1002, 32'h0, 4'd1, rd, lows, o, ra, tmo);
        checks++;
        if (rd !== OOR || o !== 1'b1) begin errors++; $display("FAIL oor_misaligned got=%h/%b want=%h/1", rd, o, OOR); end
        tick();
        checks++;
        if (oor !== 1'b0) begin errors++; $display("FAIL oor_pulse_len got=%b want=0", oor); end
        xfer(1'b0, BASE + 4 * DEP, 32'h0, 4'd0, rd, lows, o, ra, tmo);
        checks++;
        if (rd !== OOR || o !== 1'b1) begin errors++; $display("FAIL oor_range got=%h/%b want=%h/1", rd, o, OOR); end
        xfer(1'b1, BASE + 4 * DEP, 32'hFFFF_0000, 4'd2, rd, lows, o, ra, tmo);
        checks++;
        if (o !== 1'b1) begin errors++; $display("FAIL oor_write got=%b want=1", o); end
        xfer(1'b0, 32'h0, 32'h0, 4'd0, rd, lows, o, ra, tmo);
        checks++;
        if (rd !== mm[0] || o !== 1'b0) begin errors++; $display("FAIL oor_word0 got=%h/%b want=%h/0", rd, o, mm[0]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int lows; logic o, ra, tmo;
        for (int i = 0; i < 3; i++) xfer(1'b1, 32'(i * 4), $urandom, 4'd0, rd, lows, o, ra, tmo);
        for (int i = 0; i < 3; i++) begin
            xfer(1'b0, 32'(i * 4), 32'h0, 4'd0, rd, lows, o, ra, tmo);
            checks++;
            if (rd !== mm[i]) begin errors++; $display("FAIL b2b_rd%0d got=%h want=%h", i, rd, mm[i]); end
        end
        checks++;
        if (acc !== exp_acc) begin errors++; $display("FAIL b2b_acc got=%0d want=%0d", acc, exp_acc); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; int lows; logic o, ra, tmo;
        xfer(1'b1, 32'h20, 32'h0BAD_F00D, 4'd0, rd, lows, o, ra, tmo);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h1111_2222; wait_cfg = 4'd5;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0;
        tick();
        checks++;
        if (perr !== 1'b1 || pready !== 1'b0 || acc !== exp_acc) begin
            errors++; $display("FAIL abort_state got=%b/%b/%0d want=1/0/%0d", perr, pready, acc, exp_acc);
        end
        xfer(1'b0, 32'h20, 32'h0, 4'd0, rd, lows, o, ra, tmo);
        checks++;
        if (tmo || rd !== 32'h0BAD_F00D || perr !== 1'b1) begin
            errors++; $display("FAIL abort_after got=%h/%b want=0badf00d/1", rd, perr);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int lows; logic o, ra, tmo;
        xfer(1'b1, 32'h24, 32'h2424_2424, 4'd0, rd, lows, o, ra, tmo);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h24; pwdata = 32'h9999_9999; wait_cfg = 4'd5;
        tick();
        penable = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({prdata, pready, perr, oor, acc} !== 51'd0) begin
            errors++; $display("FAIL rst_mid_outputs got=%h/%b/%b/%b/%h want all zero", prdata, pready, perr, oor, acc);
        end
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        exp_acc = 16'd0;
        xfer(1'b0, 32'h24, 32'h0, 4'd0, rd, lows, o, ra, tmo);
        checks++;
        if (tmo || rd !== 32'h2424_2424 || acc !== 16'd1 || perr !== 1'b0) begin
            errors++; $display("FAIL rst_mid_mem got=%h/%0d/%b want=24242424/1/0", rd, acc, perr);
        end
    endtask

    task automatic test_mismatch();
        logic [31:0] rd; int lows; logic o, ra, tmo;
        xfer(1'b1, 32'h30, 32'h3030_3030, 4'd0, rd, lows, o, ra, tmo);
        xfer(1'b1, 32'h34, 32'h3434_3434, 4'd0, rd, lows, o, ra, tmo);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30; pwdata = 32'hCAFE_0030; wait_cfg = 4'd2;
        tick();
        penable = 1'b1; paddr = 32'h34; pwdata = 32'hBEEF_0034;
        lows = 0;
        while (pready !== 1'b1 && lows < 40) begin lows++; tick(); end
        tick();
        psel = 1'b0; penable = 1'b0;
        exp_acc = exp_acc + 16'd1;
        mm[12] = 32'hCAFE_0030;
        checks++;
        if (lows != 2 || perr !== 1'b1 || acc !== exp_acc) begin
            errors++; $display("FAIL mismatch_flag got=%0d/%b/%0d want=2/1/%0d", lows, perr, acc, exp_acc);
        end
        do_reset();
        xfer(1'b0, 32'h30, 32'h0, 4'd0, rd, lows, o, ra, tmo);
        checks++;
        if (rd !== 32'hCAFE_0030) begin errors++; $display("FAIL mismatch_latched got=%h want=cafe0030", rd); end
        xfer(1'b0, 32'h34, 32'h0, 4'd0, rd, lows, o, ra, tmo);
        checks++;
        if (rd !== 32'h3434_3434) begin errors++; $display("FAIL mismatch_other got=%h want=34343434", rd); end
    endtask

    task automatic test_idle_violation();
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h10;
        tick();
        psel = 1'b0; penable = 1'b0;
        tick();
        checks++;
        if (perr !== 1'b1 || pready !== 1'b0 || acc !== exp_acc) begin
            errors++; $display("FAIL idle_violation got=%b/%b/%0d want=1/0/%0d", perr, pready, acc, exp_acc);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d, exp_rd; int lows; logic o, ra, tmo, w; logic [3:0] ws;
        int unsigned sel, idx;
        for (int n = 0; n < 60; n++) begin
            w   = 1'($urandom_range(0, 1));
            ws  = 4'($urandom_range(0, 15));
            d   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 5) a = BASE + 32'($urandom_range(0, DEP - 1) * 4 + $urandom_range(1, 3));
            else if (sel == 6) a = BASE + 32'(4 * DEP + $urandom_range(0, 255) * 4);
            else begin
                idx = $urandom_range(0, DEP - 1);
                if (!w) begin
                    if (wq.size() == 0) w = 1'b1;
                    else idx = wq[$urandom_range(0, wq.size() - 1)];
                end
                a = BASE + 32'(idx * 4);
            end
            exp_rd = w ? 32'd0 : (m_hit(a) ? mm[m_idx(a)] : OOR);
            xfer(w, a, d, ws, rd, lows, o, ra, tmo);
            checks++;
            if (tmo || lows != int'(ws) || rd !== exp_rd || o !== !m_hit(a)) begin
                errors++;
                $display("FAIL rand%0d a=%h w=%b lows=%0d/%0d rd=%h/%h oor=%b/%b", n, a, w, lows, ws, rd, exp_rd, o, !m_hit(a));
            end
            checks++;
            if (acc !== exp_acc || perr !== 1'b0 || ra !== 1'b0) begin
                errors++; $display("FAIL rand%0d_acc got=%0d/%b/%b want=%0d/0/0", n, acc, perr, ra, exp_acc);
            end
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; int lows; logic o, ra, tmo;
        force dut.acc_cnt_o = 16'hFFFE;
        tick();
        release dut.acc_cnt_o;
        exp_acc = 16'hFFFE;
        xfer(1'b1, 32'h40, 32'h4040_4040, 4'd0, rd, lows, o, ra, tmo);
        checks++;
        if (acc !== exp_acc) begin errors++; $display("FAIL wrap_ffff got=%h want=%h", acc, exp_acc); end
        xfer(1'b0, 32'h40, 32'h0, 4'd1, rd, lows, o, ra, tmo);
        checks++;
        if (acc !== exp_acc || rd !== 32'h4040_4040) begin
            errors++; $display("FAIL wrap_zero got=%h/%h want=%h/40404040", acc, rd, exp_acc);
        end
    endtask

    initial begin
        exp_acc = 16'd0;
        test_reset();
        test_basic();
        test_wait();
        test_oor();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_mismatch();
        test_idle_violation();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
